// File: rtl/eci_wr_burst_splitter_if.sv
// Handshake bundle around the write burst splitter: upstream AW/B (s_*) and
// downstream sub-burst AW/B towards the write reorder buffer (m_*).
interface eci_wr_burst_splitter_if #(
    parameter int unsigned ECI_ADDR_BITS = 48
);
    logic [ECI_ADDR_BITS-1:0] s_awaddr;
    logic [7:0]               s_awlen;
    logic                     s_awvalid;
    logic                     s_awready;
    logic [1:0]               s_bresp;
    logic                     s_bvalid;
    logic                     s_bready;

    logic [ECI_ADDR_BITS-1:0] m_awaddr;
    logic [7:0]               m_awlen;
    logic                     m_awvalid;
    logic                     m_awready;
    logic [1:0]               m_bresp;
    logic                     m_bvalid;
    logic                     m_bready;

    // Splitter side
    modport slave (
        input  s_awaddr, s_awlen, s_awvalid, s_bready, m_awready, m_bresp, m_bvalid,
        output s_awready, s_bresp, s_bvalid, m_awaddr, m_awlen, m_awvalid, m_bready
    );

    // Environment side (upstream master plus reorder-buffer responder)
    modport master (
        output s_awaddr, s_awlen, s_awvalid, s_bready, m_awready, m_bresp, m_bvalid,
        input  s_awready, s_bresp, s_bvalid, m_awaddr, m_awlen, m_awvalid, m_bready
    );
endinterface

// File: rtl/eci_wr_burst_splitter.sv
// Splits AXI write bursts into sub-bursts of <= N_BURSTED beats and merges their B responses.
// Define WR_SPLIT_ALIGN_EN to keep sub-bursts inside N_BURSTED*BEAT_BYTES blocks and drop stray Bs.
module eci_wr_burst_splitter #(
    parameter int unsigned N_BURSTED       = 2,
    parameter int unsigned BEAT_BYTES      = 128,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned ECI_ADDR_BITS   = 48
) (
    input logic                    aclk,
    input logic                    aresetn,
    eci_wr_burst_splitter_if.slave bus
);
`ifdef WR_SPLIT_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif
    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int unsigned PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic {IDLE, SPLIT} state_e;

    state_e                   state_q, state_d;
    logic [ECI_ADDR_BITS-1:0] addr_q, addr_d, addr_next;
    logic [8:0]               rem_q, rem_d, rem_left, chunk;
    logic [8:0]               nsub_q, nsub_d;
    logic [OUT_W-1:0]         out_q, out_d;
    logic                     maw_valid_q, maw_valid_d;
    logic [ECI_ADDR_BITS-1:0] maw_addr_q, maw_addr_d;
    logic [7:0]               maw_len_q, maw_len_d;
    logic [8:0]               fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]         wptr_q, rptr_q;
    logic [OUT_W-1:0]         cnt_q;
    logic [8:0]               bcnt_q, bcnt_d, bcnt_inc, head;
    logic [1:0]               worst_q, worst_d, worst_inc;
    logic                     sb_valid_q, sb_valid_d;
    logic [1:0]               sb_resp_q, sb_resp_d;
    logic                     s_awready, m_bready;
    logic                     aw_hs, sb_hs, mb_hs, mb_cnt, push, pop;

    function automatic logic [8:0] chunk_of(input logic [ECI_ADDR_BITS-1:0] a,
                                            input logic [8:0] rem);
        logic [8:0] idx;
        logic [8:0] lim;
        idx = 9'((a >> BEAT_SHIFT) & ECI_ADDR_BITS'(N_BURSTED - 1));
        lim = 9'(N_BURSTED) - (ALIGN_EN ? idx : 9'd0);
        return (rem < lim) ? rem : lim;
    endfunction

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        nsub_d      = nsub_q;
        maw_valid_d = maw_valid_q;
        maw_addr_d  = maw_addr_q;
        maw_len_d   = maw_len_q;
        push        = 1'b0;
        s_awready   = 1'b0;
        chunk       = chunk_of(addr_q, rem_q);
        rem_left    = rem_q - chunk;
        addr_next   = addr_q + (ECI_ADDR_BITS'(chunk) << BEAT_SHIFT);
        case (state_q)
            IDLE: begin
                s_awready = aresetn && (out_q < OUT_W'(MAX_OUTSTANDING));
                if (bus.s_awvalid && s_awready) begin
                    addr_d      = bus.s_awaddr;
                    rem_d       = {1'b0, bus.s_awlen} + 9'd1;
                    nsub_d      = '0;
                    state_d     = SPLIT;
                    maw_valid_d = 1'b1;
                    maw_addr_d  = bus.s_awaddr;
                    maw_len_d   = 8'(chunk_of(bus.s_awaddr, rem_d) - 9'd1);
                end
            end
            SPLIT: begin
                if (maw_valid_q && bus.m_awready) begin
                    addr_d = addr_next;
                    rem_d  = rem_left;
                    nsub_d = nsub_q + 9'd1;
                    if (rem_left == '0) begin
                        push        = 1'b1;
                        state_d     = IDLE;
                        maw_valid_d = 1'b0;
                    end else begin
                        maw_addr_d = addr_next;
                        maw_len_d  = 8'(chunk_of(addr_next, rem_left) - 9'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        aw_hs     = bus.s_awvalid && s_awready;
        sb_hs     = sb_valid_q && bus.s_bready;
        m_bready  = aresetn && !sb_valid_q;
        mb_hs     = bus.m_bvalid && m_bready;
        mb_cnt    = mb_hs && (!ALIGN_EN || cnt_q != '0 || state_q == SPLIT);
        bcnt_inc  = bcnt_q + 9'(mb_cnt);
        worst_inc = (mb_cnt && bus.m_bresp > worst_q) ? bus.m_bresp : worst_q;
        head      = fifo_q[rptr_q];
        bcnt_d     = bcnt_inc;
        worst_d    = worst_inc;
        sb_valid_d = sb_hs ? 1'b0 : sb_valid_q;
        sb_resp_d  = sb_resp_q;
        pop        = 1'b0;
        out_d      = out_q;
        if (aw_hs && !sb_hs)      out_d = out_q + OUT_W'(1);
        else if (!aw_hs && sb_hs) out_d = out_q - OUT_W'(1);
        // A completion deferred by a pending s_b keeps any beat accepted now for the next burst.
        if (!sb_valid_q && cnt_q != '0) begin
            if (bcnt_q == head) begin
                pop        = 1'b1;
                sb_valid_d = 1'b1;
                sb_resp_d  = worst_q;
                bcnt_d     = 9'(mb_cnt);
                worst_d    = mb_cnt ? bus.m_bresp : 2'b00;
            end else if (bcnt_inc == head) begin
                pop        = 1'b1;
                sb_valid_d = 1'b1;
                sb_resp_d  = worst_inc;
                bcnt_d     = '0;
                worst_d    = '0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            nsub_q      <= '0;
            out_q       <= '0;
            maw_valid_q <= 1'b0;
            maw_addr_q  <= '0;
            maw_len_q   <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            bcnt_q      <= '0;
            worst_q     <= '0;
            sb_valid_q  <= 1'b0;
            sb_resp_q   <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            nsub_q      <= nsub_d;
            out_q       <= out_d;
            maw_valid_q <= maw_valid_d;
            maw_addr_q  <= maw_addr_d;
            maw_len_q   <= maw_len_d;
            bcnt_q      <= bcnt_d;
            worst_q     <= worst_d;
            sb_valid_q  <= sb_valid_d;
            sb_resp_q   <= sb_resp_d;
            if (push) begin
                fifo_q[wptr_q] <= nsub_d;
                wptr_q         <= nxt(wptr_q);
            end
            if (pop) rptr_q <= nxt(rptr_q);
            cnt_q <= cnt_q + OUT_W'(push) - OUT_W'(pop);
        end
    end

    assign bus.s_awready = s_awready;
    assign bus.s_bvalid  = sb_valid_q;
    assign bus.s_bresp   = sb_resp_q;
    assign bus.m_awvalid = maw_valid_q;
    assign bus.m_awaddr  = maw_addr_q;
    assign bus.m_awlen   = maw_len_q;
    assign bus.m_bready  = m_bready;
endmodule

// File: doc/eci_wr_burst_splitter.md
Name: eci_wr_burst_splitter

Overview:
- Sits directly upstream of the write reorder buffer.
- Accepts AXI write-address bursts of any length (1..256 beats) and splits each into sub-bursts of at most N_BURSTED beats, which the reorder buffer accepts.
- Counts the in-order B responses returned by the reorder buffer and returns exactly one aggregated B response per original burst, carrying the worst response code.

Parameters:
- N_BURSTED, 2, maximum beats per issued sub-burst (power of 2, 1..16).
- BEAT_BYTES, 128, address increment per beat (ECI cache line).
- MAX_OUTSTANDING, 8, maximum original bursts in flight, counted from AW accept to B handshake (power of 2).

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous, active-low
- s_awaddr  in  ECI_ADDR_BITS  original burst start address
- s_awlen  in  8  original burst length minus 1
- s_awvalid  in  1  AW valid
- s_awready  out  1  AW ready
- s_bresp  out  2  aggregated response
- s_bvalid  out  1  B valid
- s_bready  in  1  B ready
- m_awaddr  out  ECI_ADDR_BITS  sub-burst address, to reorder buffer
- m_awlen  out  8  sub-burst length minus 1 (0..N_BURSTED-1)
- m_awvalid  out  1  sub-burst valid
- m_awready  in  1  sub-burst ready
- m_bresp  in  2  sub-burst response (in order)
- m_bvalid  in  1  sub-burst response valid
- m_bready  out  1  sub-burst response ready

Behaviour:
- Reset values: s_awready=0, m_awvalid=0, m_awaddr=0, m_awlen=0, s_bvalid=0, s_bresp=0, m_bready=0 while aresetn low. All counters, the FIFO and the FSM are cleared.
- Reset mid-operation: state is dropped immediately. Outstanding sub-bursts are discarded, and the system must reset the downstream blocks together with this one.
- FSM states are IDLE and SPLIT.
- IDLE:
  - s_awready = (outstanding < MAX_OUTSTANDING).
  - On AW handshake: latch addr_C = s_awaddr, rem_C = s_awlen+1 (9 bits), nsub_C = 0, outstanding += 1, go to SPLIT.
- SPLIT:
  - s_awready = 0.
  - m_awvalid is registered and asserted the cycle after entry. m_awaddr = addr_C, m_awlen = chunk-1, with chunk = min(rem_C, N_BURSTED).
  - m_awvalid and m_awaddr/m_awlen hold stable until m_awready.
  - On handshake: addr_C += chunk*BEAT_BYTES (wrap at ECI_ADDR_BITS), rem_C -= chunk, nsub_C += 1.
  - When rem_C reaches 0: push nsub_C (9 bits) into the count FIFO (depth MAX_OUTSTANDING) and return to IDLE.
  - Back-to-back sub-bursts are allowed (m_awvalid stays high).
  - Latency from s_awvalid/s_awready handshake to first m_awvalid is 1 cycle.
- Outstanding accounting:
  - Incremented on s_aw handshake, decremented on s_b handshake.
  - A simultaneous increment and decrement leaves it unchanged.
  - The FIFO cannot overflow because outstanding bounds it.
- Response path:
  - m_bready = ~s_bvalid.
  - On an m_b handshake: bcnt_C += 1 and worst_C = max(worst_C, m_bresp), numeric max.
  - Bs may arrive before the FIFO push of the current burst; bcnt_C accumulates regardless.
  - Completion condition: FIFO non-empty, and either (bcnt_C + accepted-this-cycle) == FIFO head, or bcnt_C == head.
  - On completion: register s_bvalid=1 and s_bresp = worst including the current beat, pop the FIFO, clear bcnt_C and worst_C to 0 the same cycle.
  - s_bvalid holds until s_bready. While s_bvalid is high, no m_b is accepted (one-cycle bubble accepted).
- Ordering: responses return in AW order; no IDs.
- Protocol violation: m_bvalid with FIFO empty and not in SPLIT is counted anyway and corrupts the next completion. This is not guarded except under the optional feature.

Optional Feature:
- Macro: WR_SPLIT_ALIGN_EN.
- Defined: chunk = min(rem_C, N_BURSTED - beat_index), with beat_index = (addr_C / BEAT_BYTES) mod N_BURSTED. Sub-bursts never cross an N_BURSTED*BEAT_BYTES boundary. nsub_C reflects the actual count issued.
- Undefined: chunk = min(rem_C, N_BURSTED), alignment ignored.

Test Plan:
- Single short burst (N_BURSTED=2): awaddr=0x1000, awlen=0, m_bresp=OKAY -> one sub-burst (0x1000, len 0); one s_b with OKAY.
- Long split: awaddr=0x0, awlen=4 -> sub-bursts (0x000,len1), (0x100,len1), (0x200,len0); after 3 m_b, exactly one s_b; no s_b after only 2.
- Worst response: awlen=3, m_bresp sequence OKAY then SLVERR -> s_bresp=2'b10; next burst with all OKAY -> s_bresp=0 (worst cleared).
- Backpressure: hold m_awready=0 for 5 cycles mid-split -> m_awaddr/m_awlen stable; hold s_bready=0 -> m_bready=0, no response lost; MAX_OUTSTANDING=8 bursts without B -> s_awready=0 on the 9th.
- Alignment (WR_SPLIT_ALIGN_EN, N_BURSTED=2): awaddr=0x080, awlen=2 -> (0x080,len0), (0x100,len1); 2 m_b then one s_b. Without macro -> (0x080,len1), (0x180,len0).
- Reset mid-split: aresetn low during SPLIT with m_awvalid=1 -> m_awvalid, s_bvalid, s_awready drop to 0 asynchronously; after release, a new burst with awlen=0 completes normally.
